// File: rtl/bitstream_loader_if.sv
// AXI-stream style bitstream link between the loader and the fabric config port.
interface axi_stream_if #(
    parameter int DATA_WIDTH = 8
) ();
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;

    modport master (output tvalid, output tdata, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/bitstream_loader.sv
// Packs host nibbles into bitstream words, buffers them in a small FIFO and
// streams them to the fabric, framing every WORDS_PER_FRAME words with tlast.
module bitstream_loader #(
    parameter int BITSTREAM_DATA_WIDTH = 8,
    parameter int IN_WIDTH             = 4,
    parameter int WORDS_PER_FRAME      = 2,
    parameter int FRAME_COUNT          = 36,
    parameter int FIFO_DEPTH           = 4
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               host_valid,
    input  logic [IN_WIDTH-1:0]                host_data,
    output logic                               host_ready,
    output logic                               cfg,
    axi_stream_if.master                       cfg_bitstream,
    input  logic                               fabric_cfg_ready,
    output logic                               busy,
    output logic                               done,
    output logic [$clog2(FRAME_COUNT+1)-1:0]   frames_sent
);
    localparam int BDW   = BITSTREAM_DATA_WIDTH;
    localparam int NIBS  = BDW / IN_WIDTH;
    localparam int TOTAL = FRAME_COUNT * WORDS_PER_FRAME;
    localparam int NB_W  = $clog2(NIBS + 1);
    localparam int WF_W  = $clog2(WORDS_PER_FRAME + 1);
    localparam int WP_W  = $clog2(TOTAL + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int FS_W  = $clog2(FRAME_COUNT + 1);

    typedef enum logic [2:0] {IDLE, KICK, STREAM, DRAIN, DONE} state_t;

    state_t             state, state_next;
    logic [NB_W-1:0]    nib_cnt;
    logic [WF_W-1:0]    word_in_frame;
    logic [WP_W-1:0]    words_packed;
    logic [BDW-1:0]     pack_reg, word_next;
    logic [BDW-1:0]     mem_data [FIFO_DEPTH];
    logic               mem_last [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_count;
    logic               tvalid, accept, push, pop, frame_end, kick_entry;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = KICK;
            KICK:    state_next = STREAM;
            STREAM:  if (words_packed == WP_W'(TOTAL) && fifo_count == '0) state_next = DRAIN;
            DRAIN:   if (fabric_cfg_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        cfg        = (state == KICK);
        busy       = (state == KICK) || (state == STREAM) || (state == DRAIN);
        host_ready = (state == STREAM) && (words_packed < WP_W'(TOTAL))
                     && (fifo_count < CNT_W'(FIFO_DEPTH));
        tvalid     = ((state == STREAM) || (state == DRAIN)) && (fifo_count != '0);
    end

    // Gating with tvalid keeps the bus at zero while idle or after reset.
    assign cfg_bitstream.tvalid = tvalid;
    assign cfg_bitstream.tdata  = tvalid ? mem_data[rd_ptr] : '0;
    assign cfg_bitstream.tlast  = tvalid ? mem_last[rd_ptr] : 1'b0;

    assign kick_entry = (state == IDLE) && start;
    assign accept     = host_valid && host_ready;
    assign word_next  = (pack_reg << IN_WIDTH) | BDW'(host_data);
    assign push       = accept && (nib_cnt == NB_W'(NIBS - 1));
    assign pop        = tvalid && cfg_bitstream.tready;
    assign frame_end  = (word_in_frame == WF_W'(WORDS_PER_FRAME - 1));

    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= word_next;
            mem_last[wr_ptr] <= frame_end;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || kick_entry) begin
            nib_cnt       <= '0;
            word_in_frame <= '0;
            words_packed  <= '0;
            pack_reg      <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            frames_sent   <= '0;
            done          <= 1'b0;
        end else begin
            if (push) begin
                pack_reg      <= '0;
                nib_cnt       <= '0;
                words_packed  <= words_packed + 1'b1;
                word_in_frame <= frame_end ? '0 : word_in_frame + 1'b1;
                wr_ptr        <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end else if (accept) begin
                pack_reg <= word_next;
                nib_cnt  <= nib_cnt + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
                if (mem_last[rd_ptr] && frames_sent < FS_W'(FRAME_COUNT))
                    frames_sent <= frames_sent + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
            if (state == DRAIN && fabric_cfg_ready) done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_bitstream_loader.sv
// Directed bench for bitstream_loader: packing, backpressure, drain, start-ignore, reset.
module tb_bitstream_loader;
    logic       clk = 1'b0;
    logic       rst_n, start, host_valid, fabric_cfg_ready;
    logic [3:0] host_data;
    logic       host_ready, cfg, busy, done;
    logic [5:0] frames_sent;

    axi_stream_if #(.DATA_WIDTH(8)) axis ();

    bitstream_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .host_valid(host_valid),
        .host_data(host_data), .host_ready(host_ready), .cfg(cfg),
        .cfg_bitstream(axis), .fabric_cfg_ready(fabric_cfg_ready),
        .busy(busy), .done(done), .frames_sent(frames_sent)
    );

    always #5 clk = ~clk;

    int   vecs = 0, miscompares = 0;
    int   cfg_cnt = 0;
    int   idx = 0;
    logic [7:0] rx_data [$];
    logic       rx_last [$];

    // Transfers and cfg pulses are observed mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (axis.tvalid && axis.tready) begin
            rx_data.push_back(axis.tdata);
            rx_last.push_back(axis.tlast);
        end
        if (cfg) cfg_cnt++;
    end

    function automatic logic [3:0] nib(int i);
        case (i)
            0: return 4'hA;
            1: return 4'h5;
            2: return 4'h3;
            3: return 4'hC;
            default: return 4'((i * 7 + 3) & 15);
        endcase
    endfunction

    function automatic logic [7:0] exp_word(int k);
        return {nib(2 * k), nib(2 * k + 1)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed(int cycles);
        logic acc;
        for (int c = 0; c < cycles; c++) begin
            host_valid = (idx < 144);
            host_data  = nib(idx);
            #3;
            acc = host_valid && host_ready;
            tick();
            if (acc) idx++;
        end
        host_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, " host_ready"}, 32'(host_ready), 0);
        check({tag, " cfg"}, 32'(cfg), 0);
        check({tag, " tvalid"}, 32'(axis.tvalid), 0);
        check({tag, " tlast"}, 32'(axis.tlast), 0);
        check({tag, " tdata"}, 32'(axis.tdata), 0);
        check({tag, " busy"}, 32'(busy), 0);
        check({tag, " done"}, 32'(done), 0);
        check({tag, " frames_sent"}, 32'(frames_sent), 0);
    endtask

    task automatic check_stream(string tag, int base);
        int bad = 0;
        check({tag, " word count"}, 32'(rx_data.size() - base), 72);
        for (int k = 0; k < 72 && base + k < rx_data.size(); k++)
            if (rx_data[base + k] !== exp_word(k) || rx_last[base + k] !== 1'(k % 2)) bad++;
        check({tag, " word contents"}, 32'(bad), 0);
    endtask

    task automatic kick_session();
        start = 1'b1;
        tick();
        check("kick cfg", 32'(cfg), 1);
        check("kick busy", 32'(busy), 1);
        check("kick done cleared", 32'(done), 0);
        check("kick frames_sent", 32'(frames_sent), 0);
        start = 1'b0;
        tick();
        check("stream host_ready", 32'(host_ready), 1);
    endtask

    task automatic finish_drain(string tag);
        repeat (3) tick();
        check({tag, " drain busy"}, 32'(busy), 1);
        check({tag, " drain done"}, 32'(done), 0);
        check({tag, " frames_sent"}, 32'(frames_sent), 36);
        fabric_cfg_ready = 1'b1;
        tick();
        check({tag, " done set"}, 32'(done), 1);
        check({tag, " busy clear"}, 32'(busy), 0);
        fabric_cfg_ready = 1'b0;
        tick();
        check({tag, " done sticky"}, 32'(done), 1);
    endtask

    initial begin
        int base;
        rst_n = 1'b0; start = 1'b0; host_valid = 1'b0; host_data = '0;
        fabric_cfg_ready = 1'b0; axis.tready = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Session 1: packing, backpressure, start-ignore, drain.
        base = rx_data.size();
        idx = 0;
        kick_session();
        check("stream tvalid empty", 32'(axis.tvalid), 0);
        feed(2);
        check("pack A5 tdata", 32'(axis.tdata), 32'hA5);
        check("pack A5 tlast", 32'(axis.tlast), 0);
        feed(2);
        check("held under stall", 32'(axis.tdata), 32'hA5);
        axis.tready = 1'b1;
        start = 1'b1;
        tick();
        axis.tready = 1'b0;
        start = 1'b0;
        check("pack 3C tdata", 32'(axis.tdata), 32'h3C);
        check("pack 3C tlast", 32'(axis.tlast), 1);
        feed(20);
        check("bp host_ready low", 32'(host_ready), 0);
        check("bp nibbles taken", 32'(idx), 10);
        check("bp tdata stable", 32'(axis.tdata), 32'h3C);
        check("bp tvalid", 32'(axis.tvalid), 1);
        axis.tready = 1'b1;
        feed(200);
        finish_drain("s1");
        check_stream("s1", base);
        check("s1 single cfg", 32'(cfg_cnt), 1);

        // Session 2: reset in the middle of frame 10.
        base = rx_data.size();
        idx = 0;
        kick_session();
        feed(42);
        check("s2 frames before reset", 32'(frames_sent), 10);
        check("s2 words before reset", 32'(rx_data.size() - base), 20);
        rst_n = 1'b0;
        tick();
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        tick();
        check("s2 cfg count", 32'(cfg_cnt), 2);

        // Session 3: fresh full load after the reset.
        base = rx_data.size();
        idx = 0;
        kick_session();
        feed(200);
        finish_drain("s3");
        check_stream("s3", base);
        check("s3 cfg count", 32'(cfg_cnt), 3);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end
endmodule
